// File: rtl/mem_pkg.sv
// Shared types and constants for the memory responder slice.
package mem_pkg;

   // Responder FSM states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   // Latched operation kind
   typedef enum logic {
      OP_RD = 1'b0,
      OP_WR = 1'b1
   } op_t;

   // Legal LATENCY range and the wait-counter width that covers it
   localparam int unsigned LATENCY_MIN = 1;
   localparam int unsigned LATENCY_MAX = 15;
   localparam int unsigned CNT_W       = 4;

endpackage

// File: rtl/mem_array.sv
// Single-port word RAM: synchronous write, registered read, no reset.
module mem_array #(
   parameter int unsigned ADDR_W = 8,
   parameter int unsigned DATA_W = 32
) (
   input  logic              clk,
   input  logic              we,
   input  logic [ADDR_W-1:0] idx,
   input  logic [DATA_W-1:0] wd,
   output logic [DATA_W-1:0] rd
);

   logic [DATA_W-1:0] mem [2**ADDR_W];

   // Write port and registered read port share one index
   always_ff @(posedge clk) begin
      if (we) begin
         mem[idx] <= wd;
      end
      rd <= mem[idx];
   end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: latches a request, waits LATENCY cycles, then
// answers with a one-cycle ready pulse (err for illegal requests).
// LATENCY must lie in LATENCY_MIN..LATENCY_MAX from mem_pkg.
module mem_responder
   import mem_pkg::*;
#(
   parameter int unsigned ADDR_W  = 8,
   parameter int unsigned DATA_W  = 32,
   parameter int unsigned LATENCY = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              mem_read,
   input  logic              mem_write,
   input  logic [31:0]       addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata,
   output logic              ready,
   output logic              busy,
   output logic              err
);

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   op_t                op_q;
   logic [ADDR_W-1:0]  idx_q;
   logic [DATA_W-1:0]  wd_q;
   logic               ill_q;
   logic               accept;
   logic               rd_cap;
   logic               arr_we;
   logic [ADDR_W-1:0]  arr_idx;
   logic [DATA_W-1:0]  arr_rd;
   logic               req_ill;
   op_t                req_op;
   logic               unused_addr;

   assign unused_addr = ^addr[31:ADDR_W+2];
   assign req_ill     = (addr[1:0] != 2'b00) || (mem_read && mem_write);
   assign req_op      = (mem_write && !mem_read) ? OP_WR : OP_RD;

   // In IDLE the array already reads the incoming address, so the registered
   // read word is in place before WAIT ends even with LATENCY=1.
   assign arr_idx = (state_q == IDLE) ? addr[ADDR_W+1:2] : idx_q;
   assign arr_we  = (state_q == RESP) && (op_q == OP_WR) && !ill_q;

   assign ready = (state_q == RESP);
   assign busy  = (state_q != IDLE);
   assign err   = (state_q == RESP) && ill_q;

   // State and wait counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Next-state, counter and strobe decode
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      accept  = 1'b0;
      rd_cap  = 1'b0;
      case (state_q)
         IDLE: begin
            if (mem_read || mem_write) begin
               state_d = WAIT;
               cnt_d   = CNT_W'(LATENCY - 1);
               accept  = 1'b1;
            end
         end
         WAIT: begin
            if (cnt_q == '0) begin
               state_d = RESP;
               rd_cap  = 1'b1;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Request latch and response data register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         op_q  <= OP_RD;
         idx_q <= '0;
         wd_q  <= '0;
         ill_q <= 1'b0;
         rdata <= '0;
      end else begin
         if (accept) begin
            op_q  <= req_op;
            idx_q <= addr[ADDR_W+1:2];
            wd_q  <= wdata;
            ill_q <= req_ill;
         end
         if (rd_cap) begin
            if (ill_q) begin
               rdata <= '0;
            end else if (op_q == OP_RD) begin
               rdata <= arr_rd;
            end
         end
      end
   end

   mem_array #(
      .ADDR_W (ADDR_W),
      .DATA_W (DATA_W)
   ) u_array (
      .clk (clk),
      .we  (arr_we),
      .idx (arr_idx),
      .wd  (wd_q),
      .rd  (arr_rd)
   );

endmodule

// File: tb/tb_mem_responder.sv
// Directed self-checking bench: one responder with LATENCY=2, one with LATENCY=1.
module tb_mem_responder;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        rd2 = 1'b0, wr2 = 1'b0;
   logic [31:0] a2 = '0, d2 = '0;
   logic [31:0] rdata2;
   logic        ready2, busy2, err2;

   logic        rd1 = 1'b0, wr1 = 1'b0;
   logic [31:0] a1 = '0, d1 = '0;
   logic [31:0] rdata1;
   logic        ready1, busy1, err1;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_responder #(
      .ADDR_W  (8),
      .DATA_W  (32),
      .LATENCY (2)
   ) u_dut2 (
      .clk       (clk),
      .rst       (rst),
      .mem_read  (rd2),
      .mem_write (wr2),
      .addr      (a2),
      .wdata     (d2),
      .rdata     (rdata2),
      .ready     (ready2),
      .busy      (busy2),
      .err       (err2)
   );

   mem_responder #(
      .ADDR_W  (8),
      .DATA_W  (32),
      .LATENCY (1)
   ) u_dut1 (
      .clk       (clk),
      .rst       (rst),
      .mem_read  (rd1),
      .mem_write (wr1),
      .addr      (a1),
      .wdata     (d1),
      .rdata     (rdata1),
      .ready     (ready1),
      .busy      (busy1),
      .err       (err1)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // One access on the selected instance; checks latency and busy, returns rdata/err
   task automatic acc(input string tag, input bit sel, input int lat,
                      input logic r, input logic w, input logic [31:0] a, input logic [31:0] d,
                      output logic [31:0] rd_o, output logic er_o);
      int  n;
      logic busy_ok;
      @(negedge clk);
      if (sel) begin rd1 = r; wr1 = w; a1 = a; d1 = d; end
      else     begin rd2 = r; wr2 = w; a2 = a; d2 = d; end
      @(posedge clk);
      n = 0;
      busy_ok = 1'b1;
      for (int i = 1; i <= 20; i++) begin
         @(negedge clk);
         busy_ok &= (sel ? busy1 : busy2);
         if (sel ? ready1 : ready2) begin
            n = i;
            break;
         end
      end
      rd_o = sel ? rdata1 : rdata2;
      er_o = sel ? err1 : err2;
      if (sel) begin rd1 = 1'b0; wr1 = 1'b0; end
      else     begin rd2 = 1'b0; wr2 = 1'b0; end
      check({tag, "_lat"}, n, lat + 1);
      check({tag, "_busy"}, {31'd0, busy_ok}, 32'd1);
      @(negedge clk);
      check({tag, "_idle"}, {30'd0, (sel ? ready1 : ready2), (sel ? busy1 : busy2)}, 32'd0);
   endtask

   initial begin
      logic [31:0] rv;
      logic        ev;
      int          pulses;
      int          t1, t2;
      logic [31:0] v1, v2;
      logic        mid_busy;

      // Reset held for 3 cycles
      repeat (3) @(negedge clk);
      check("rst_ready", {31'd0, ready2}, 32'd0);
      check("rst_busy",  {31'd0, busy2},  32'd0);
      check("rst_err",   {31'd0, err2},   32'd0);
      check("rst_rdata", rdata2, 32'd0);
      check("rst_rdata1", rdata1, 32'd0);
      rst = 1'b0;

      // Idle with no request: ready never pulses
      pulses = 0;
      repeat (10) begin
         @(negedge clk);
         if (ready2 || busy2) pulses++;
      end
      check("idle_pulses", pulses, 0);

      // Write then read
      acc("wr10", 1'b0, 2, 1'b0, 1'b1, 32'h10, 32'hDEADBEEF, rv, ev);
      check("wr10_err", {31'd0, ev}, 32'd0);
      acc("rd10", 1'b0, 2, 1'b1, 1'b0, 32'h10, 32'h0, rv, ev);
      check("rd10_data", rv, 32'hDEADBEEF);
      check("rd10_err", {31'd0, ev}, 32'd0);

      // Illegal: read and write together leaves the word untouched
      acc("wr20", 1'b0, 2, 1'b0, 1'b1, 32'h20, 32'h11112222, rv, ev);
      acc("both20", 1'b0, 2, 1'b1, 1'b1, 32'h20, 32'hFFFFFFFF, rv, ev);
      check("both20_err", {31'd0, ev}, 32'd1);
      check("both20_data", rv, 32'd0);
      acc("rd20", 1'b0, 2, 1'b1, 1'b0, 32'h20, 32'h0, rv, ev);
      check("rd20_data", rv, 32'h11112222);
      check("rd20_err", {31'd0, ev}, 32'd0);

      // Illegal: misaligned read
      acc("rd21", 1'b0, 2, 1'b1, 1'b0, 32'h21, 32'h0, rv, ev);
      check("rd21_err", {31'd0, ev}, 32'd1);
      check("rd21_data", rv, 32'd0);

      // Reset during WAIT aborts the write
      acc("wr40", 1'b0, 2, 1'b0, 1'b1, 32'h40, 32'hCAFEF00D, rv, ev);
      @(negedge clk);
      wr2 = 1'b1; a2 = 32'h40; d2 = 32'h12345678;
      @(posedge clk);
      @(negedge clk);
      mid_busy = busy2;
      check("abort_wait_busy", {31'd0, mid_busy}, 32'd1);
      rst = 1'b1;
      wr2 = 1'b0;
      #1;
      check("abort_state", {30'd0, ready2, busy2}, 32'd0);
      @(negedge clk);
      rst = 1'b0;
      pulses = 0;
      repeat (6) begin
         @(negedge clk);
         if (ready2) pulses++;
      end
      check("abort_pulses", pulses, 0);
      acc("rd40", 1'b0, 2, 1'b1, 1'b0, 32'h40, 32'h0, rv, ev);
      check("rd40_data", rv, 32'hCAFEF00D);

      // Aliasing: 0x400 maps to word 0
      acc("wr400", 1'b0, 2, 1'b0, 1'b1, 32'h400, 32'hA5A5A5A5, rv, ev);
      acc("rd0", 1'b0, 2, 1'b1, 1'b0, 32'h0, 32'h0, rv, ev);
      check("alias_data", rv, 32'hA5A5A5A5);

      // LATENCY=1: seed two words, then back-to-back reads with mem_read held
      acc("l1wr0", 1'b1, 1, 1'b0, 1'b1, 32'h0, 32'h0BADF00D, rv, ev);
      acc("l1wr4", 1'b1, 1, 1'b0, 1'b1, 32'h4, 32'h600DCAFE, rv, ev);
      @(negedge clk);
      rd1 = 1'b1; a1 = 32'h0;
      @(posedge clk);
      pulses = 0; t1 = 0; t2 = 0; v1 = '0; v2 = '0;
      mid_busy = 1'b1;
      for (int i = 1; i <= 12; i++) begin
         @(negedge clk);
         if (i == 3) mid_busy = busy1;
         if (ready1) begin
            pulses++;
            if (pulses == 1) begin
               t1 = i; v1 = rdata1; a1 = 32'h4;
            end else begin
               t2 = i; v2 = rdata1; rd1 = 1'b0;
            end
         end
      end
      rd1 = 1'b0;
      check("b2b_pulses", pulses, 2);
      check("b2b_first", t1, 2);
      check("b2b_gap", t2 - t1, 3);
      check("b2b_gap_busy", {31'd0, mid_busy}, 32'd0);
      check("b2b_data0", v1, 32'h0BADF00D);
      check("b2b_data4", v2, 32'h600DCAFE);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
